// File: rtl/bank_name_lookup_pipe.sv
// Two-level ROM name lookup (index ROM -> name ROM), one request in flight, status-coded response.
// Latency: 3 edges accept->rsp_valid for ROM hits, 1 edge for not-found/index-range; response held until rsp_ready.
module bank_name_lookup_pipe #(
  parameter int                 ADDR_W          = 12,
  parameter int                 INDEX_DEPTH     = 2638,
  parameter int                 NIDX_W          = 6,
  parameter int                 NAME_COUNT      = 59,
  parameter int                 NAME_W          = 100,
  parameter logic [NAME_W-1:0]  NOT_FOUND_NAME  = NAME_W'("BANK NAME NOT FOUND"),
  parameter string              INDEX_INIT_FILE = "./bindb/bank_names_indices.mif",
  parameter string              NAME_INIT_FILE  = "./bindb/bank_names.mif"
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_index,
  input  logic              req_found,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [NAME_W-1:0] rsp_name,
  output logic [1:0]        rsp_status,
  output logic              busy,
  output logic [15:0]       cnt_ok,
  output logic [15:0]       cnt_err
);

  if (INDEX_INIT_FILE == "" || NAME_INIT_FILE == "") begin : g_bad_init
    $error("bank_name_lookup_pipe: ROM init file names must not be empty");
  end

  localparam logic [1:0] ST_OK        = 2'b00;
  localparam logic [1:0] ST_NOT_FOUND = 2'b01;
  localparam logic [1:0] ST_IDX_RANGE = 2'b10;
  localparam logic [1:0] ST_NAME_RNG  = 2'b11;

  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(INDEX_DEPTH);
  localparam logic [NIDX_W:0] NCOUNT_C = (NIDX_W+1)'(NAME_COUNT);

  typedef enum logic [1:0] {IDLE, RD_IDX, RD_NAME, RESP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        status_q, status_d;
  logic [15:0]       cnt_ok_q, cnt_ok_d, cnt_err_q, cnt_err_d;

  // ROM contents are loaded from the init files by the implementation flow
  logic [NIDX_W-1:0] idx_rom  [0:INDEX_DEPTH-1];
  logic [NAME_W-1:0] name_rom [0:NAME_COUNT-1];
  logic [NIDX_W-1:0] nidx_q;
  logic [NAME_W-1:0] name_rd_q;

  logic accept, handshake, nidx_bad;

  assign req_ready = (state_q == IDLE) && resetn;
  assign accept    = req_valid && req_ready;
  assign handshake = (state_q == RESP) && rsp_ready;
  assign nidx_bad  = {1'b0, nidx_q} >= NCOUNT_C;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    status_d  = status_q;
    cnt_ok_d  = cnt_ok_q;
    cnt_err_d = cnt_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d = req_index;
          if (!req_found) begin
            status_d = ST_NOT_FOUND;
            state_d  = RESP;
          end else if ({1'b0, req_index} >= DEPTH_C) begin
            status_d = ST_IDX_RANGE;
            state_d  = RESP;
          end else begin
            status_d = ST_OK;
            state_d  = RD_IDX;
          end
        end
      end
      RD_IDX:  state_d = RD_NAME;
      RD_NAME: begin
        state_d = RESP;
        if (nidx_bad) status_d = ST_NAME_RNG;
      end
      RESP: begin
        if (handshake) begin
          state_d = IDLE;
          if (status_q == ST_OK) begin
            if (cnt_ok_q != 16'hFFFF) cnt_ok_d = cnt_ok_q + 16'd1;
          end else begin
            if (cnt_err_q != 16'hFFFF) cnt_err_d = cnt_err_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      status_q  <= ST_OK;
      cnt_ok_q  <= '0;
      cnt_err_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      status_q  <= status_d;
      cnt_ok_q  <= cnt_ok_d;
      cnt_err_q <= cnt_err_d;
    end
  end

  // Block-RAM read ports: no reset, enabled only in the state that consumes them
  always_ff @(posedge CLOCK_50) begin
    if (state_q == RD_IDX) nidx_q <= idx_rom[addr_q];
    if (state_q == RD_NAME && !nidx_bad) name_rd_q <= name_rom[nidx_q];
  end

  assign rsp_valid  = (state_q == RESP);
  assign rsp_status = rsp_valid ? status_q : 2'b00;
  assign rsp_name   = !rsp_valid ? '0 : ((status_q == ST_OK) ? name_rd_q : NOT_FOUND_NAME);
  assign busy       = (state_q != IDLE);
  assign cnt_ok     = cnt_ok_q;
  assign cnt_err    = cnt_err_q;

endmodule

// File: tb/tb_bank_name_lookup_pipe.sv
// Directed + randomized bench for bank_name_lookup_pipe against a table-level reference model.
module tb_bank_name_lookup_pipe;
  localparam int DEPTH  = 2638;
  localparam int NCOUNT = 59;

  logic        CLOCK_50 = 1'b0;
  logic        resetn = 1'b1;
  logic        req_valid = 1'b0;
  logic [11:0] req_index = '0;
  logic        req_found = 1'b0;
  logic        rsp_ready = 1'b0;
  logic        req_ready, rsp_valid, busy;
  logic [99:0] rsp_name;
  logic [1:0]  rsp_status;
  logic [15:0] cnt_ok, cnt_err;

  bank_name_lookup_pipe dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index), .req_found(req_found),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_name(rsp_name), .rsp_status(rsp_status),
    .busy(busy), .cnt_ok(cnt_ok), .cnt_err(cnt_err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int          checks = 0;
  int          failures = 0;
  logic [5:0]  idx_mem  [DEPTH];
  logic [99:0] name_mem [NCOUNT];
  logic [99:0] nf_name;
  int          exp_ok = 0;
  int          exp_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected response straight from the lookup rules
  task automatic model(input int idx, input bit found,
                       output logic [1:0] st, output logic [99:0] nm, output int lat);
    if (!found) begin
      st = 2'b01; nm = nf_name; lat = 1;
    end else if (idx >= DEPTH) begin
      st = 2'b10; nm = nf_name; lat = 1;
    end else if (int'(idx_mem[idx]) >= NCOUNT) begin
      st = 2'b11; nm = nf_name; lat = 3;
    end else begin
      st = 2'b00; nm = name_mem[idx_mem[idx]]; lat = 3;
    end
  endtask

  // Called 1 time unit after a rising edge with the DUT idle
  task automatic run_req(input int idx, input bit found, input int hold);
    logic [1:0]  st;
    logic [99:0] nm;
    int          lat, got;
    model(idx, found, st, nm, lat);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_index = idx[11:0]; req_found = found;
    @(posedge CLOCK_50); #1;
    req_valid = 1'b0; req_index = 12'($urandom); req_found = 1'($urandom);
    got = 1;
    while (rsp_valid !== 1'b1 && got < 8) begin
      @(posedge CLOCK_50); #1;
      got++;
    end
    chk("latency", got, lat);
    chk("rsp_name", rsp_name, nm);
    chk("rsp_status", rsp_status, st);
    chk("busy_resp", busy, 1);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_index = 12'($urandom); req_found = 1'($urandom);
      @(posedge CLOCK_50); #1;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_name", rsp_name, nm);
      chk("hold_status", rsp_status, st);
      chk("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge CLOCK_50); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    if (st == 2'b00) begin
      if (exp_ok < 65535) exp_ok++;
    end else begin
      if (exp_err < 65535) exp_err++;
    end
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_req_ready", req_ready, 1);
    chk("post_busy", busy, 0);
    chk("idle_name_zero", rsp_name, 0);
    chk("idle_status_zero", rsp_status, 0);
    chk("cnt_ok", cnt_ok, exp_ok);
    chk("cnt_err", cnt_err, exp_err);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [151:0] nf_full;
    logic [127:0] rnd;
    int           idx;
    bit           found;

    nf_full = "BANK NAME NOT FOUND";
    nf_name = nf_full[99:0];
    for (int i = 0; i < DEPTH; i++) idx_mem[i] = 6'($urandom_range(0, 63));
    idx_mem[0] = 6'd5;  idx_mem[7] = 6'd60; idx_mem[8] = 6'd58;
    idx_mem[9] = 6'd59; idx_mem[DEPTH-1] = 6'd0;
    for (int i = 0; i < NCOUNT; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      name_mem[i] = rnd[99:0];
    end
    for (int i = 0; i < DEPTH; i++) dut.idx_rom[i] = idx_mem[i];
    for (int i = 0; i < NCOUNT; i++) dut.name_rom[i] = name_mem[i];

    // Asynchronous reset, before any clock edge
    #2 resetn = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_name", rsp_name, 0);
    chk("rst_rsp_status", rsp_status, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_cnt_ok", cnt_ok, 0);
    chk("rst_cnt_err", cnt_err, 0);
    @(posedge CLOCK_50); @(posedge CLOCK_50); #1;
    resetn = 1'b1;
    @(posedge CLOCK_50); #1;
    chk("rel_req_ready", req_ready, 1);

    // rsp_ready outside RESP does nothing
    rsp_ready = 1'b1;
    @(posedge CLOCK_50); #1;
    rsp_ready = 1'b0;
    chk("stray_ready_valid", rsp_valid, 0);
    chk("stray_ready_cnt", cnt_ok + cnt_err, 0);

    run_req(0, 1'b1, 0);
    run_req(0, 1'b0, 0);
    run_req(DEPTH, 1'b1, 0);
    run_req(4095, 1'b1, 0);
    run_req(DEPTH-1, 1'b1, 1);
    run_req(7, 1'b1, 0);
    run_req(8, 1'b1, 0);
    run_req(9, 1'b1, 0);
    run_req(0, 1'b1, 10);

    // Reset while in RD_NAME aborts the lookup
    req_valid = 1'b1; req_index = 12'd0; req_found = 1'b1;
    @(posedge CLOCK_50); #1;
    req_valid = 1'b0;
    @(posedge CLOCK_50); #1;
    resetn = 1'b0;
    #1;
    exp_ok = 0; exp_err = 0;
    chk("abort_busy", busy, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_cnt_ok", cnt_ok, 0);
    chk("abort_cnt_err", cnt_err, 0);
    @(posedge CLOCK_50); #1;
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLOCK_50); #1;
      chk("abort_no_rsp", rsp_valid, 0);
    end
    run_req(0, 1'b1, 0);

    for (int n = 0; n < 40; n++) begin
      idx   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(DEPTH, 4095))
                                          : int'($urandom_range(0, DEPTH-1));
      found = ($urandom_range(0, 4) != 0);
      run_req(idx, found, int'($urandom_range(0, 3)));
    end

    // Saturation: preload counters near the top, then cross it
    dut.cnt_ok_q  = 16'hFFFD; exp_ok  = 65533;
    dut.cnt_err_q = 16'hFFFD; exp_err = 65533;
    for (int i = 0; i < 3; i++) run_req(0, 1'b1, 0);
    for (int i = 0; i < 3; i++) run_req(DEPTH, 1'b1, 0);
    chk("sat_ok", cnt_ok, 16'hFFFF);
    chk("sat_err", cnt_err, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
